// File: rtl/multi_channel_misr.sv
`default_nettype none
// ============================================================================
// Module      : multi_channel_misr
// Description : NCH independent N-bit Galois MISRs sharing one feedback
//               polynomial. A capture window is framed by start/done/ack;
//               window length, seed, channel mask and polynomial are latched
//               at start. Optional golden-signature comparison is compiled
//               in when MISR_CMP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_channel_misr #(
    parameter int N     = 32,
    parameter int NCH   = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               en_i,
    input  logic [NCH-1:0]     chan_mask_i,
    input  logic [CNT_W-1:0]   len_i,
    input  logic [N-1:0]       seed_i,
    input  logic [N-1:0]       coeff_i,
    input  logic [NCH*N-1:0]   data_i,
    input  logic               ack_i,
`ifdef MISR_CMP_EN
    input  logic [NCH*N-1:0]   golden_i,
    output logic               pass_o,
    output logic [NCH-1:0]     fail_mask_o,
`endif
    output logic [NCH*N-1:0]   sig_o,
    output logic               done_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]     c_misr_rst = {{(N-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_misr     [NCH];
    logic [N-1:0]     w_misr_nxt [NCH];
    logic [N-1:0]     w_step     [NCH];
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [CNT_W-1:0] r_len,   w_len_nxt;
    logic [NCH-1:0]   r_mask,  w_mask_nxt;
    logic [N-1:0]     r_coeff, w_coeff_nxt;
    logic             w_load;
    logic             w_capture;

    // Per-channel Galois step and done-gated signature output
    generate
        for (genvar c = 0; c < NCH; c++) begin : g_chan
            assign w_step[c] = {r_misr[c][N-2:0], 1'b0}
                             ^ data_i[c*N +: N]
                             ^ (r_coeff & {N{r_misr[c][N-1]}});
            assign sig_o[c*N +: N] = (r_state == S_DONE) ? r_misr[c] : '0;
        end
    endgenerate

    assign done_o = (r_state == S_DONE);
    assign busy_o = (r_state == S_RUN);

    // Next-state, load and capture decisions
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_count_nxt = r_count;
        w_len_nxt   = r_len;
        w_mask_nxt  = r_mask;
        w_coeff_nxt = r_coeff;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_load = 1'b1;
                end
            end
            S_RUN: begin
                // Abort wins over a simultaneous capture strobe
                if (abort_i) begin
                    w_state_nxt = S_IDLE;
                end else if (en_i) begin
                    w_capture   = 1'b1;
                    w_count_nxt = r_count + c_cnt_one;
                    if (r_count == (r_len - c_cnt_one)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Restart without an idle cycle when ack and start coincide
                if (ack_i) begin
                    if (start_i) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_len_nxt   = len_i;
            w_mask_nxt  = chan_mask_i;
            w_coeff_nxt = coeff_i;
            w_count_nxt = '0;
            // A zero-length window completes immediately with the seed
            w_state_nxt = (len_i == '0) ? S_DONE : S_RUN;
        end

        for (int c = 0; c < NCH; c++) begin
            if (w_load) begin
                w_misr_nxt[c] = seed_i;
            end else if (w_capture && r_mask[c]) begin
                w_misr_nxt[c] = w_step[c];
            end else begin
                w_misr_nxt[c] = r_misr[c];
            end
        end
    end

    // State, configuration and MISR registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_len   <= '0;
            r_mask  <= '0;
            r_coeff <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_misr[c] <= c_misr_rst;
            end
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_len   <= w_len_nxt;
            r_mask  <= w_mask_nxt;
            r_coeff <= w_coeff_nxt;
            for (int c = 0; c < NCH; c++) begin
                r_misr[c] <= w_misr_nxt[c];
            end
        end
    end

`ifdef MISR_CMP_EN
    logic [NCH-1:0] w_fail;
    logic [NCH-1:0] r_fail_mask;
    logic           r_pass;
    logic           w_enter_done;

    // Compare against the value the MISRs take on the edge entering DONE
    generate
        for (genvar c = 0; c < NCH; c++) begin : g_cmp
            assign w_fail[c] = w_mask_nxt[c] & (w_misr_nxt[c] != golden_i[c*N +: N]);
        end
    endgenerate

    assign w_enter_done = (w_state_nxt == S_DONE) && ((r_state != S_DONE) || w_load);

    // Verdict captured on DONE entry, cleared on leaving DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_mask <= '0;
            r_pass      <= 1'b0;
        end else if (w_enter_done) begin
            r_fail_mask <= w_fail;
            r_pass      <= ~|w_fail;
        end else if (w_state_nxt != S_DONE) begin
            r_fail_mask <= '0;
            r_pass      <= 1'b0;
        end
    end

    assign fail_mask_o = r_fail_mask;
    assign pass_o      = r_pass;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_misr.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_channel_misr
// Description : Directed self-checking bench for multi_channel_misr. A small
//               4-bit single-channel instance covers hand-computed windows;
//               a 32-bit 4-channel instance covers masking, strobe gaps,
//               abort, restart, reset and (with MISR_CMP_EN) comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_channel_misr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Large instance: N=32, NCH=4
    logic         start, abort, en, ack;
    logic [3:0]   mask;
    logic [15:0]  len;
    logic [31:0]  seed, coeff;
    logic [127:0] data;
    logic [127:0] sig;
    logic         done, busy;
`ifdef MISR_CMP_EN
    logic [127:0] golden;
    logic         pass;
    logic [3:0]   fmask;
`endif

    // Small instance: N=4, NCH=1
    logic         s_start, s_abort, s_en, s_ack;
    logic [0:0]   s_mask;
    logic [15:0]  s_len;
    logic [3:0]   s_seed, s_coeff, s_data;
    logic [3:0]   s_sig;
    logic         s_done, s_busy;
`ifdef MISR_CMP_EN
    logic [3:0]   s_golden;
    logic         s_pass;
    logic [0:0]   s_fmask;
`endif

    multi_channel_misr #(.N(32), .NCH(4), .CNT_W(16)) u_big (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .en_i(en),
        .chan_mask_i(mask), .len_i(len), .seed_i(seed), .coeff_i(coeff),
        .data_i(data), .ack_i(ack),
`ifdef MISR_CMP_EN
        .golden_i(golden), .pass_o(pass), .fail_mask_o(fmask),
`endif
        .sig_o(sig), .done_o(done), .busy_o(busy)
    );

    multi_channel_misr #(.N(4), .NCH(1), .CNT_W(16)) u_small (
        .clk(clk), .rst_n(rst_n), .start_i(s_start), .abort_i(s_abort), .en_i(s_en),
        .chan_mask_i(s_mask), .len_i(s_len), .seed_i(s_seed), .coeff_i(s_coeff),
        .data_i(s_data), .ack_i(s_ack),
`ifdef MISR_CMP_EN
        .golden_i(s_golden), .pass_o(s_pass), .fail_mask_o(s_fmask),
`endif
        .sig_o(s_sig), .done_o(s_done), .busy_o(s_busy)
    );

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

    // Reference Galois step written directly from the bit equations
    function automatic logic [31:0] ref_step(input logic [31:0] q, input logic [31:0] d,
                                             input logic [31:0] cf);
        logic [31:0] r;
        r[0] = d[0] ^ (cf[0] & q[31]);
        for (int k = 1; k < 32; k++) r[k] = d[k] ^ (cf[k] & q[31]) ^ q[k-1];
        return r;
    endfunction

    task automatic big_start(input logic [31:0] sd, input logic [15:0] ln,
                             input logic [3:0] mk, input logic [31:0] cf);
        @(negedge clk);
        start = 1'b1; seed = sd; len = ln; mask = mk; coeff = cf;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic big_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; abort = 0; en = 0; ack = 0; mask = 0; len = 0; seed = 0; coeff = 0; data = 0;
        s_start = 0; s_abort = 0; s_en = 0; s_ack = 0; s_mask = 0; s_len = 0;
        s_seed = 0; s_coeff = 0; s_data = 0;
`ifdef MISR_CMP_EN
        golden = 0; s_golden = 0;
`endif
        repeat (2) @(negedge clk);
        n_checks++;
        if ({done, busy, sig, s_done, s_busy, s_sig} !== '0)
            $display("FAIL reset_outputs: got done=%b busy=%b sig=%h sdone=%b sbusy=%b ssig=%h, want all 0",
                     done, busy, sig, s_done, s_busy, s_sig);
        else n_pass++;
`ifdef MISR_CMP_EN
        n_checks++;
        if ({pass, fmask} !== 5'b0) $display("FAIL reset_cmp: got pass=%b fmask=%b, want 0", pass, fmask);
        else n_pass++;
`endif
        rst_n = 1'b1;
    endtask

    // seed 0001, poly 0011, zero data: 0001->0010->0100->1000->0011->0110
    task automatic test_small_window(input logic [15:0] ln, input logic [3:0] exp_sig);
        int cyc;
        @(negedge clk);
        s_start = 1; s_seed = 4'b0001; s_coeff = 4'b0011; s_len = ln; s_mask = 1'b1;
        s_data = 4'b0000; s_en = 1;
        @(negedge clk);
        s_start = 0;
        cyc = 0;
        while (s_done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc != int'(ln)) $display("FAIL small_latency_len%0d: got %0d cycles, want %0d", ln, cyc, ln);
        else n_pass++;
        n_checks++;
        if (s_sig !== exp_sig) $display("FAIL small_sig_len%0d: got %b, want %b", ln, s_sig, exp_sig);
        else n_pass++;
        s_en = 0; s_ack = 1;
        @(negedge clk);
        s_ack = 0;
    endtask

    task automatic test_len_zero();
        big_start(32'hA5A5_A5A5, 16'd0, 4'hF, CRC_POLY);
        n_checks++;
        if ({done, busy} !== 2'b10) $display("FAIL len0_flags: got done=%b busy=%b, want 1 0", done, busy);
        else n_pass++;
        n_checks++;
        if (sig !== {4{32'hA5A5_A5A5}}) $display("FAIL len0_sig: got %h, want %h", sig, {4{32'hA5A5_A5A5}});
        else n_pass++;
        big_ack();
        n_checks++;
        if ({done, busy, sig} !== '0) $display("FAIL len0_ack: got done=%b busy=%b sig=%h, want 0", done, busy, sig);
        else n_pass++;
    endtask

    task automatic test_mask_gaps();
        logic [31:0] exp [4];
        logic [127:0] held;
        int cnt, cyc;
        bit ok;
        for (int c = 0; c < 4; c++) exp[c] = 32'h1357_9BDF;
        big_start(32'h1357_9BDF, 16'd8, 4'b0101, CRC_POLY);
        cnt = 0; cyc = 0; ok = 1;
        while (cnt < 8 && cyc < 200) begin
            en   = 1'($urandom_range(0, 1));
            data = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            if (en) begin
                for (int c = 0; c < 4; c++)
                    if (mask[c]) exp[c] = ref_step(exp[c], data[c*32 +: 32], CRC_POLY);
                cnt++;
            end
            @(negedge clk);
            cyc++;
            if (done !== (cnt == 8)) ok = 0;
            if (busy !== (cnt != 8)) ok = 0;
        end
        en = 0;
        n_checks++;
        if (!ok || cnt != 8) $display("FAIL gaps_sequence: got captures=%0d seq_ok=%0d, want 8 1", cnt, ok);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (sig[c*32 +: 32] !== exp[c])
                $display("FAIL gaps_sig_ch%0d: got %h, want %h", c, sig[c*32 +: 32], exp[c]);
            else n_pass++;
        end
        held = sig;
        en = 1; data = {4{32'hFFFF_0000}};
        repeat (2) @(negedge clk);
        en = 0;
        n_checks++;
        if (sig !== held) $display("FAIL done_frozen: got %h, want %h", sig, held);
        else n_pass++;
        big_ack();
    endtask

    task automatic test_abort();
        logic [31:0] exp;
        big_start(32'hDEAD_BEEF, 16'd10, 4'hF, CRC_POLY);
        en = 1; data = {4{32'h0F0F_0F0F}};
        repeat (2) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0; en = 0;
        n_checks++;
        if ({done, busy} !== 2'b00) $display("FAIL abort_idle: got done=%b busy=%b, want 0 0", done, busy);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (done !== 1'b0) $display("FAIL abort_no_done: got done=%b, want 0", done);
        else n_pass++;
        // Fresh run: three captures of distinct words on every channel
        exp = 32'h0000_00FF;
        big_start(32'h0000_00FF, 16'd3, 4'hF, CRC_POLY);
        en = 1;
        for (int i = 0; i < 3; i++) begin
            data = {4{32'h8000_0001 + 32'(i)}};
            exp  = ref_step(exp, 32'h8000_0001 + 32'(i), CRC_POLY);
            @(negedge clk);
        end
        en = 0;
        n_checks++;
        if (done !== 1'b1 || sig !== {4{exp}})
            $display("FAIL abort_fresh_sig: got done=%b sig=%h, want 1 %h", done, sig, {4{exp}});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] held;
        logic [31:0]  exp;
        held = sig;
        start = 1;
        @(negedge clk);
        start = 0;
        n_checks++;
        if (done !== 1'b1 || sig !== held)
            $display("FAIL start_wo_ack: got done=%b sig=%h, want 1 %h", done, sig, held);
        else n_pass++;
        seed = 32'hCAFE_F00D; len = 16'd2; mask = 4'hF; coeff = CRC_POLY;
        start = 1; ack = 1;
        @(negedge clk);
        start = 0; ack = 0;
        n_checks++;
        if ({busy, done} !== 2'b10) $display("FAIL restart_flags: got busy=%b done=%b, want 1 0", busy, done);
        else n_pass++;
        en = 1; data = '0;
        repeat (2) @(negedge clk);
        en = 0;
        exp = ref_step(ref_step(32'hCAFE_F00D, 32'h0, CRC_POLY), 32'h0, CRC_POLY);
        n_checks++;
        if (done !== 1'b1 || sig !== {4{exp}})
            $display("FAIL restart_sig: got done=%b sig=%h, want 1 %h", done, sig, {4{exp}});
        else n_pass++;
        big_ack();
        // Asynchronous reset in the middle of a run
        big_start(32'h1111_2222, 16'd10, 4'hF, CRC_POLY);
        en = 1; data = {4{32'h3333_4444}};
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL pre_reset_busy: got %b, want 1", busy);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({done, busy, sig} !== '0) $display("FAIL async_reset: got done=%b busy=%b sig=%h, want 0", done, busy, sig);
        else n_pass++;
        @(negedge clk);
        en = 0; rst_n = 1'b1;
    endtask

`ifdef MISR_CMP_EN
    task automatic test_compare();
        logic [31:0] exp;
        exp = ref_step(ref_step(32'h2468_ACE0, 32'h0123_4567, CRC_POLY), 32'h89AB_CDEF, CRC_POLY);
        for (int pass_run = 0; pass_run < 2; pass_run++) begin
            golden = {4{exp}};
            if (pass_run == 0) golden[2*32 +: 32] = exp ^ 32'h1;
            big_start(32'h2468_ACE0, 16'd2, 4'hF, CRC_POLY);
            en = 1; data = {4{32'h0123_4567}};
            @(negedge clk);
            data = {4{32'h89AB_CDEF}};
            @(negedge clk);
            en = 0;
            n_checks++;
            if (pass_run == 0 && {pass, fmask} !== 5'b0_0100)
                $display("FAIL cmp_ch2_bad: got pass=%b fmask=%b, want 0 0100", pass, fmask);
            else if (pass_run == 1 && {pass, fmask} !== 5'b1_0000)
                $display("FAIL cmp_all_good: got pass=%b fmask=%b, want 1 0000", pass, fmask);
            else n_pass++;
            big_ack();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_small_window(16'd4, 4'b0011);
        test_small_window(16'd5, 4'b0110);
        test_len_zero();
        test_mask_gaps();
        test_abort();
        test_back_to_back();
`ifdef MISR_CMP_EN
        test_compare();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
